exec_muldiv: RTL and testbench
==============================

Name: exec_muldiv

Overview:
- Parametrised, shared, iterative RISC-V M-extension unit for the dual-issue execute stage.
- Either issue lane hands it a request over a valid/ready handshake. The request carries the lane ID and rd.
- Multiply is radix-2^MUL_BITS, several bits per cycle. Divide is restoring, 1 bit per cycle.
- The result returns over a valid/ready handshake tagged with lane and rd. kill_i, driven from the branch-mispredict flush, aborts any in-flight operation.

Parameters:
- XLEN, 32, operand/result width.
- LANES, 2, number of issue lanes sharing the unit.
- LANE_W, 1, width of the lane tag; LANE_W = max(1, clog2(LANES)).
- MUL_BITS, 4, multiplier bits retired per MUL cycle; must divide XLEN.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  unit can accept a request.
- req_lane_i  in  LANE_W  issuing lane.
- req_funct3_i  in  3  M-ext funct3 (000 MUL … 111 REMU).
- req_rs1_i  in  XLEN  bypassed rs1 operand.
- req_rs2_i  in  XLEN  bypassed rs2 operand.
- req_rd_i  in  5  destination register.
- kill_i  in  1  flush; abort current operation.
- resp_valid_o  out  1  result valid.
- resp_ready_i  in  1  writeback accepts result.
- resp_lane_o  out  LANE_W  lane tag of result.
- resp_rd_o  out  5  rd of result.
- resp_data_o  out  XLEN  result.
- busy_o  out  1  state != IDLE.

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- Reset values: state IDLE; resp_valid_o=0, resp_lane_o=0, resp_rd_o=0, resp_data_o=0, busy_o=0. req_ready_o=1 whenever state is IDLE, including while in reset.
- States: IDLE, MUL, DIV, FIX, DONE.
- req_ready_o = (state==IDLE). A request is accepted on the edge where req_valid_i && req_ready_o && !kill_i.
- On accept, latch lane, rd, funct3, operands, and operand signs:
  - MUL/MULH/MULHSU take signed rs1.
  - MULH/DIV/REM take signed rs2.
  - Signed operands are converted to magnitudes.
- Accept transitions:
  - funct3[2]=0 -> MUL, counter=0.
  - funct3[2]=1 with normal operands -> DIV, counter=0.
  - Divide by zero -> DONE directly. Quotient = all-ones; remainder = rs1.
  - Signed overflow (rs1 = 0x80000000, rs2 = all-ones, DIV/REM only) -> DONE directly. Quotient = rs1; remainder = 0.
- MUL: each cycle adds partial product for MUL_BITS multiplier bits into a 2*XLEN accumulator. After XLEN/MUL_BITS cycles -> FIX.
- DIV: one restoring step per cycle on the magnitudes. After XLEN cycles -> FIX.
- FIX (one cycle): apply sign correction.
  - Product is negated when the signs differ.
  - Quotient is negated when the signs differ; remainder takes the sign of the dividend.
  - Select result: low XLEN bits for MUL, high XLEN bits for MULH*, quotient or remainder for divides.
  - Transition -> DONE, resp_valid_o=1.
- Latency, counted from the accepting edge to the edge that sets resp_valid_o:
  - MUL*: XLEN/MUL_BITS+1 edges (9 at defaults).
  - DIV*: XLEN+1 edges (33).
  - Special-case divides: 1 edge.
- DONE: resp_* outputs held stable until resp_valid_o && resp_ready_i. Then -> IDLE and resp_valid_o=0.
  - Minimum one idle cycle between a response and the next accept; no same-cycle turnaround.
- kill_i: synchronous, highest priority.
  - From any state -> IDLE next edge, resp_valid_o=0, any pending response discarded.
  - kill_i in the same cycle as req_valid_i blocks acceptance.
  - kill_i in DONE drops the response even if resp_ready_i=1.
- All arithmetic is mod 2^XLEN. Intermediates are XLEN+1 bits for divide and 2*XLEN bits for multiply.
- Asynchronous reset mid-operation returns to the reset state immediately; no response is produced.

Optional Feature:
- Macro: MULDIV_REUSE_EN.
- Defined:
  - On each divide completion, store rs1, rs2, signedness, quotient and remainder.
  - A later divide with identical rs1, rs2 and signedness goes IDLE -> DONE in 1 edge, returning the stored quotient or remainder. This covers the DIV-then-REM pair.
  - Stored entry is invalidated by reset, by kill_i, and by any MUL.
- Undefined: no storage; every divide takes XLEN+1 edges.

Test Plan:
- Reset: assert rst_n_i=0 mid-DIV -> resp_valid_o=0 and busy_o=0 immediately; req_ready_o=1 after release.
- MULH, lane 1, rs1=0xFFFFFFFF (-1), rs2=0x00000002 -> after 9 edges resp_valid_o=1, data=0xFFFFFFFF, lane=1, and rd returned unchanged.
- DIV, rs1=-7 (0xFFFFFFF9), rs2=2 -> data=0xFFFFFFFD after 33 edges. REM on the same operands -> 0xFFFFFFFF, in 33 edges without MULDIV_REUSE_EN and 1 edge with it.
- Divide special cases:
  - DIVU x/0, rs1=0x1234 -> 0xFFFFFFFF after 1 edge.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
- Backpressure: MUL 3*5 with resp_ready_i=0 for 4 cycles -> data=15 stable, req_ready_o=0 throughout. Release -> IDLE next edge.
- Kill: assert kill_i on cycle 5 of a DIV -> no response, IDLE next edge. kill_i together with req_valid_i -> no accept.

Source files
------------

// File: rtl/exec_muldiv_if.sv
// Request/response handshake bundle for the shared M-extension unit.
interface exec_muldiv_if #(
    parameter int XLEN   = 32,
    parameter int LANE_W = 1
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [LANE_W-1:0] req_lane_i;
    logic [2:0]        req_funct3_i;
    logic [XLEN-1:0]   req_rs1_i;
    logic [XLEN-1:0]   req_rs2_i;
    logic [4:0]        req_rd_i;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic [LANE_W-1:0] resp_lane_o;
    logic [4:0]        resp_rd_o;
    logic [XLEN-1:0]   resp_data_o;

    modport master (
        output req_valid_i, req_lane_i, req_funct3_i, req_rs1_i, req_rs2_i, req_rd_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_lane_o, resp_rd_o, resp_data_o
    );

    modport slave (
        input  req_valid_i, req_lane_i, req_funct3_i, req_rs1_i, req_rs2_i, req_rd_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_lane_o, resp_rd_o, resp_data_o
    );
endinterface

// File: rtl/exec_muldiv.sv
// Shared iterative RV M-extension unit: radix-2^MUL_BITS multiply, restoring divide.
// Define MULDIV_REUSE_EN to keep the last divide result for 1-edge DIV/REM pairs.
module exec_muldiv #(
    parameter int XLEN     = 32,
    parameter int LANES    = 2,
    parameter int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1,
    parameter int MUL_BITS = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         kill_i,
    exec_muldiv_if.slave bus,
    output logic         busy_o
);
    localparam int NMUL  = XLEN / MUL_BITS;
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t              r_state;
    logic                r_resp_valid;
    logic [XLEN-1:0]     r_resp_data;
    logic [LANE_W-1:0]   r_lane;
    logic [4:0]          r_rd;
    logic [2:0]          r_f3;
    logic                r_neg_a;
    logic                r_neg_b;
    logic [XLEN-1:0]     r_opa;
    logic [XLEN-1:0]     r_opb;
    logic [2*XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_rem;
    logic [CNT_W-1:0]    r_cnt;

    logic [2:0]          w_f3;
    logic                w_sa;
    logic                w_sb;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_div0;
    logic                w_ovf;
    logic [XLEN-1:0]     w_spec_q;
    logic [XLEN-1:0]     w_spec_r;
    logic [2*XLEN-1:0]   w_pp;
    logic [2*XLEN-1:0]   w_acc_nxt;
    logic [XLEN:0]       w_shift;
    logic [XLEN:0]       w_trial;
    logic                w_ge;
    logic [XLEN-1:0]     w_rem_nxt;
    logic [XLEN-1:0]     w_quo_nxt;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_q;
    logic [XLEN-1:0]     w_r;
    logic [XLEN-1:0]     w_fix_data;

`ifdef MULDIV_REUSE_EN
    logic                r_rv_valid;
    logic [XLEN-1:0]     r_rv_a;
    logic [XLEN-1:0]     r_rv_b;
    logic                r_rv_sgn;
    logic [XLEN-1:0]     r_rv_q;
    logic [XLEN-1:0]     r_rv_r;
    logic [XLEN-1:0]     r_rs1;
    logic [XLEN-1:0]     r_rs2;
    logic                w_hit;
`endif

    assign w_f3     = bus.req_funct3_i;
    assign w_sa     = w_f3[2] ? ~w_f3[0] : (w_f3[1:0] != 2'b11);
    assign w_sb     = w_f3[2] ? ~w_f3[0] : (w_f3[1:0] == 2'b01);
    assign w_neg_a  = w_sa & bus.req_rs1_i[XLEN-1];
    assign w_neg_b  = w_sb & bus.req_rs2_i[XLEN-1];
    assign w_mag_a  = w_neg_a ? -bus.req_rs1_i : bus.req_rs1_i;
    assign w_mag_b  = w_neg_b ? -bus.req_rs2_i : bus.req_rs2_i;
    assign w_div0   = (bus.req_rs2_i == '0);
    assign w_ovf    = ~w_f3[0] && (bus.req_rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.req_rs2_i == '1);
    assign w_spec_q = w_div0 ? '1 : bus.req_rs1_i;
    assign w_spec_r = w_div0 ? bus.req_rs1_i : '0;

    assign w_pp      = r_mcand * {{(2*XLEN-MUL_BITS){1'b0}}, r_opa[MUL_BITS-1:0]};
    assign w_acc_nxt = r_acc + w_pp;
    assign w_shift   = {r_rem, r_opa[XLEN-1]};
    assign w_trial   = w_shift - {1'b0, r_opb};
    assign w_ge      = ~w_trial[XLEN];
    assign w_rem_nxt = w_ge ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quo_nxt = {r_opa[XLEN-2:0], w_ge};

    // FIX retires the final MUL/DIV step together with sign correction,
    // so the iterating states run one step short of the full count.
    assign w_prod = (r_neg_a ^ r_neg_b) ? -w_acc_nxt : w_acc_nxt;
    assign w_q    = (r_neg_a ^ r_neg_b) ? -w_quo_nxt : w_quo_nxt;
    assign w_r    = r_neg_a ? -w_rem_nxt : w_rem_nxt;

    always_comb begin
        w_fix_data = '0;
        if (r_f3[2])
            w_fix_data = r_f3[1] ? w_r : w_q;
        else if (r_f3[1:0] == 2'b00)
            w_fix_data = w_prod[XLEN-1:0];
        else
            w_fix_data = w_prod[2*XLEN-1:XLEN];
    end

`ifdef MULDIV_REUSE_EN
    assign w_hit = r_rv_valid && (bus.req_rs1_i == r_rv_a) && (bus.req_rs2_i == r_rv_b)
                && (r_rv_sgn == ~w_f3[0]);
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_lane       <= '0;
            r_rd         <= '0;
            r_f3         <= '0;
            r_neg_a      <= 1'b0;
            r_neg_b      <= 1'b0;
            r_opa        <= '0;
            r_opb        <= '0;
            r_mcand      <= '0;
            r_acc        <= '0;
            r_rem        <= '0;
            r_cnt        <= '0;
`ifdef MULDIV_REUSE_EN
            r_rv_valid   <= 1'b0;
            r_rv_a       <= '0;
            r_rv_b       <= '0;
            r_rv_sgn     <= 1'b0;
            r_rv_q       <= '0;
            r_rv_r       <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
`endif
        end else if (kill_i) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
`ifdef MULDIV_REUSE_EN
            r_rv_valid   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        r_lane  <= bus.req_lane_i;
                        r_rd    <= bus.req_rd_i;
                        r_f3    <= w_f3;
                        r_neg_a <= w_neg_a;
                        r_neg_b <= w_neg_b;
                        r_opa   <= w_mag_a;
                        r_opb   <= w_mag_b;
                        r_mcand <= {{XLEN{1'b0}}, w_mag_b};
                        r_acc   <= '0;
                        r_rem   <= '0;
                        r_cnt   <= '0;
`ifdef MULDIV_REUSE_EN
                        r_rs1   <= bus.req_rs1_i;
                        r_rs2   <= bus.req_rs2_i;
`endif
                        if (!w_f3[2]) begin
                            r_state <= S_MUL;
`ifdef MULDIV_REUSE_EN
                            r_rv_valid <= 1'b0;
`endif
                        end else if (w_div0 || w_ovf) begin
                            r_state      <= S_DONE;
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= w_f3[1] ? w_spec_r : w_spec_q;
`ifdef MULDIV_REUSE_EN
                            r_rv_valid   <= 1'b1;
                            r_rv_a       <= bus.req_rs1_i;
                            r_rv_b       <= bus.req_rs2_i;
                            r_rv_sgn     <= ~w_f3[0];
                            r_rv_q       <= w_spec_q;
                            r_rv_r       <= w_spec_r;
                        end else if (w_hit) begin
                            r_state      <= S_DONE;
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= w_f3[1] ? r_rv_r : r_rv_q;
`endif
                        end else begin
                            r_state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    r_acc   <= w_acc_nxt;
                    r_mcand <= r_mcand << MUL_BITS;
                    r_opa   <= r_opa >> MUL_BITS;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(NMUL - 2))
                        r_state <= S_FIX;
                end
                S_DIV: begin
                    r_opa <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(XLEN - 2))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_state      <= S_DONE;
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= w_fix_data;
`ifdef MULDIV_REUSE_EN
                    if (r_f3[2]) begin
                        r_rv_valid <= 1'b1;
                        r_rv_a     <= r_rs1;
                        r_rv_b     <= r_rs2;
                        r_rv_sgn   <= ~r_f3[0];
                        r_rv_q     <= w_q;
                        r_rv_r     <= w_r;
                    end
`endif
                end
                S_DONE: begin
                    if (bus.resp_ready_i) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o  = (r_state == S_IDLE);
    assign bus.resp_valid_o = r_resp_valid;
    assign bus.resp_lane_o  = r_lane;
    assign bus.resp_rd_o    = r_rd;
    assign bus.resp_data_o  = r_resp_data;
    assign busy_o           = (r_state != S_IDLE);
endmodule

// File: tb/tb_exec_muldiv.sv
// Directed scoreboard bench for exec_muldiv: results, latency, backpressure, kill and reset.
module tb_exec_muldiv;
    logic clk_i;
    logic rst_n_i;
    logic kill_i;
    logic busy_o;

    int checks;
    int failures;

    exec_muldiv_if #(.XLEN(32), .LANE_W(1)) bus ();

    exec_muldiv #(.XLEN(32), .LANES(2), .LANE_W(1), .MUL_BITS(4)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .kill_i  (kill_i),
        .bus     (bus),
        .busy_o  (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic        lane;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t sb[$];

    logic        rv_valid;
    logic [31:0] rv_a;
    logic [31:0] rv_b;
    logic        rv_sgn;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] res;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        res = '0;
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; res = p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; res = p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; res = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; res = p[63:32]; end
            3'd4: res = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: res = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: res = (b == 0) ? a : a % b;
        endcase
        return res;
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int l;
        if (!f3[2]) begin
            rv_valid = 1'b0;
            return 32 / 4 + 1;
        end
        if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            l = 1;
`ifdef MULDIV_REUSE_EN
        else if (rv_valid && rv_a == a && rv_b == b && rv_sgn == ~f3[0])
            l = 1;
`endif
        else
            l = 33;
        rv_valid = 1'b1;
        rv_a     = a;
        rv_b     = b;
        rv_sgn   = ~f3[0];
        return l;
    endfunction

    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic lane, input logic [4:0] rd, input int hold, output logic [31:0] got);
        exp_t e;
        int   lat;
        e.data = model(f3, a, b);
        e.lane = lane;
        e.rd   = rd;
        e.lat  = exp_lat(f3, a, b);
        sb.push_back(e);
        @(negedge clk_i);
        bus.req_valid_i  = 1'b1;
        bus.req_funct3_i = f3;
        bus.req_rs1_i    = a;
        bus.req_rs2_i    = b;
        bus.req_lane_i   = lane;
        bus.req_rd_i     = rd;
        bus.resp_ready_i = (hold == 0);
        @(posedge clk_i);
        #1;
        bus.req_valid_i = 1'b0;
        lat = 1;
        while (!bus.resp_valid_o && lat < 200) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        e = sb.pop_front();
        got = bus.resp_data_o;
        chk({tag, ":valid"}, 64'(bus.resp_valid_o), 64'd1);
        chk({tag, ":latency"}, 64'(lat), 64'(e.lat));
        chk({tag, ":data"}, 64'(bus.resp_data_o), 64'(e.data));
        chk({tag, ":lane"}, 64'(bus.resp_lane_o), 64'(e.lane));
        chk({tag, ":rd"}, 64'(bus.resp_rd_o), 64'(e.rd));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i);
            #1;
            chk({tag, ":hold_valid"}, 64'(bus.resp_valid_o), 64'd1);
            chk({tag, ":hold_data"}, 64'(bus.resp_data_o), 64'(e.data));
            chk({tag, ":hold_ready"}, 64'(bus.req_ready_o), 64'd0);
        end
        bus.resp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk({tag, ":post_valid"}, 64'(bus.resp_valid_o), 64'd0);
        chk({tag, ":post_ready"}, 64'(bus.req_ready_o), 64'd1);
        chk({tag, ":post_busy"}, 64'(busy_o), 64'd0);
    endtask

    logic [2:0]  t_f3 [10] = '{3'd0, 3'd3, 3'd2, 3'd1, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd7};
    logic [31:0] t_a  [10] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                               32'd100, 32'hFFFF_FF9C, 32'd7, 32'h8000_0000, 32'hDEAD_BEEF};
    logic [31:0] t_b  [10] = '{32'h9ABC_DEF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3,
                               32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd1, 32'd0};

    initial begin
        logic [31:0] got;
        logic        seen;
        checks   = 0;
        failures = 0;
        rv_valid = 1'b0;
        rv_a     = '0;
        rv_b     = '0;
        rv_sgn   = 1'b0;
        rst_n_i  = 1'b0;
        kill_i   = 1'b0;
        bus.req_valid_i  = 1'b0;
        bus.req_lane_i   = '0;
        bus.req_funct3_i = '0;
        bus.req_rs1_i    = '0;
        bus.req_rs2_i    = '0;
        bus.req_rd_i     = '0;
        bus.resp_ready_i = 1'b1;

        #3;
        chk("rst:resp_valid", 64'(bus.resp_valid_o), 64'd0);
        chk("rst:resp_lane", 64'(bus.resp_lane_o), 64'd0);
        chk("rst:resp_rd", 64'(bus.resp_rd_o), 64'd0);
        chk("rst:resp_data", 64'(bus.resp_data_o), 64'd0);
        chk("rst:busy", 64'(busy_o), 64'd0);
        chk("rst:req_ready", 64'(bus.req_ready_o), 64'd1);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        do_op("mulh_lane1", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 5'd17, 0, got);
        chk("mulh_lane1:const", 64'(got), 64'hFFFF_FFFF);
        do_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 5'd5, 0, got);
        chk("div_m7_2:const", 64'(got), 64'hFFFF_FFFD);
        do_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd6, 0, got);
        chk("rem_m7_2:const", 64'(got), 64'hFFFF_FFFF);
        do_op("divu_by0", 3'd5, 32'h1234, 32'd0, 1'b0, 5'd7, 0, got);
        chk("divu_by0:const", 64'(got), 64'hFFFF_FFFF);
        do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd8, 0, got);
        chk("rem_ovf:const", 64'(got), 64'h0);
        do_op("mul_bp", 3'd0, 32'd3, 32'd5, 1'b0, 5'd9, 4, got);
        chk("mul_bp:const", 64'(got), 64'd15);

        for (int i = 0; i < 10; i++)
            do_op($sformatf("tbl%0d", i), t_f3[i], t_a[i], t_b[i], 1'(i), 5'(i + 10), 0, got);

        // kill on the fifth cycle of a divide
        @(negedge clk_i);
        bus.req_valid_i  = 1'b1;
        bus.req_funct3_i = 3'd5;
        bus.req_rs1_i    = 32'd1000;
        bus.req_rs2_i    = 32'd3;
        @(posedge clk_i);
        #1;
        bus.req_valid_i = 1'b0;
        chk("kill:busy_before", 64'(busy_o), 64'd1);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        kill_i   = 1'b0;
        rv_valid = 1'b0;
        chk("kill:busy", 64'(busy_o), 64'd0);
        chk("kill:req_ready", 64'(bus.req_ready_o), 64'd1);
        chk("kill:resp_valid", 64'(bus.resp_valid_o), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            #1;
            if (bus.resp_valid_o) seen = 1'b1;
        end
        chk("kill:no_response", 64'(seen), 64'd0);

        @(negedge clk_i);
        bus.req_valid_i  = 1'b1;
        bus.req_funct3_i = 3'd0;
        kill_i           = 1'b1;
        @(posedge clk_i);
        #1;
        bus.req_valid_i = 1'b0;
        kill_i          = 1'b0;
        chk("kill_valid:no_accept", 64'(busy_o), 64'd0);

        // asynchronous reset in the middle of a divide
        @(negedge clk_i);
        bus.req_valid_i  = 1'b1;
        bus.req_funct3_i = 3'd4;
        bus.req_rs1_i    = 32'd12345;
        bus.req_rs2_i    = 32'd7;
        @(posedge clk_i);
        #1;
        bus.req_valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #2;
        rst_n_i  = 1'b0;
        rv_valid = 1'b0;
        #1;
        chk("rst_mid:resp_valid", 64'(bus.resp_valid_o), 64'd0);
        chk("rst_mid:busy", 64'(busy_o), 64'd0);
        chk("rst_mid:req_ready", 64'(bus.req_ready_o), 64'd1);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_rel:req_ready", 64'(bus.req_ready_o), 64'd1);
        chk("rst_rel:busy", 64'(busy_o), 64'd0);

        do_op("div_after_rst", 3'd4, 32'd12345, 32'd7, 1'b1, 5'd31, 0, got);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
